// File: rtl/circ_router_buf.sv
// circ_router_buf: five-port buffered router for one node of a circulant network C(NODES; 1, S2).
// Define CIRC_ROUTER_STATS_EN to add per-output forward counters (fwd_cnt) and a drop counter (drop_cnt).
module circ_router_buf #(
  parameter int NODES  = 5,
  parameter int S2     = 2,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            router_name,
  input  logic [4:0]                   in_valid,
  input  logic [5*(ADDR_W+DATA_W)-1:0] in_data,
  output logic [4:0]                   in_ready,
  output logic [4:0]                   out_valid,
  output logic [5*(ADDR_W+DATA_W)-1:0] out_data,
  input  logic [4:0]                   out_ready,
  output logic                         err_drop
`ifdef CIRC_ROUTER_STATS_EN
  ,
  output logic [5*16-1:0]              fwd_cnt,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int PW    = ADDR_W + DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0]  NODES_W = NODES[ADDR_W:0];
  localparam logic [ADDR_W:0]  S2_W    = S2[ADDR_W:0];
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PW-1:0]    mem_q     [5][DEPTH];
  logic [PTR_W-1:0] wrPtr_q   [5];
  logic [PTR_W-1:0] rdPtr_q   [5];
  logic [CNT_W-1:0] count_q   [5];
  logic [CNT_W-1:0] count_d   [5];
  logic [PW-1:0]    head      [5];
  logic [ADDR_W:0]  dst       [5];
  logic [ADDR_W:0]  dr        [5];
  logic [ADDR_W:0]  dl        [5];
  logic [2:0]       route     [5];
  logic [4:0]       req       [5];
  logic [2:0]       grantIdx  [5];
  logic [PW-1:0]    outData_q [5];
  logic [PW-1:0]    outData_d [5];
  logic [2:0]       ptr_q     [5];
  logic [2:0]       ptr_d     [5];
  logic [4:0]       headValid, headBad, wrEn, popEn;
  logic [4:0]       outFree, grantValid;
  logic [4:0]       outValid_q, outValid_d;
  logic [ADDR_W:0]  nameW;

  function automatic logic [2:0] wrapAdd(input logic [2:0] p, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  assign nameW = {1'b0, router_name};

  always_comb begin
    for (int c = 0; c < 5; c++) begin
      in_ready[c] = (count_q[c] != DEPTH_C);
      wrEn[c]     = in_valid[c] & (count_q[c] != DEPTH_C);
    end
  end

  // Ring distance without a divider: one conditional add of NODES covers dst < router_name.
  always_comb begin
    for (int c = 0; c < 5; c++) begin
      head[c]      = mem_q[c][rdPtr_q[c]];
      headValid[c] = (count_q[c] != '0);
      dst[c]       = {1'b0, head[c][PW-1 -: ADDR_W]};
      headBad[c]   = (dst[c] >= NODES_W);
      if (dst[c] >= nameW) dr[c] = dst[c] - nameW;
      else                 dr[c] = dst[c] + NODES_W - nameW;
      dl[c] = NODES_W - dr[c];
      if (dr[c] == '0)          route[c] = 3'd0;
      else if (dr[c] <= dl[c])  route[c] = (dr[c] >= S2_W) ? 3'd2 : 3'd1;
      else                      route[c] = (dl[c] >= S2_W) ? 3'd4 : 3'd3;
    end
  end

  always_comb begin
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 5; c++) begin
        req[o][c] = headValid[c] & ~headBad[c] & (route[c] == 3'(o));
      end
    end
  end

  // Scanning from the far end back to ptr leaves the first requester at or after ptr as winner.
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      grantValid[o] = 1'b0;
      grantIdx[o]   = 3'd0;
      for (int k = 4; k >= 0; k--) begin
        if (req[o][wrapAdd(ptr_q[o], 3'(k))]) begin
          grantValid[o] = 1'b1;
          grantIdx[o]   = wrapAdd(ptr_q[o], 3'(k));
        end
      end
      outFree[o] = ~outValid_q[o] | out_ready[o];
    end
  end

  always_comb begin
    popEn = headValid & headBad;
    for (int c = 0; c < 5; c++) begin
      for (int o = 0; o < 5; o++) begin
        if (outFree[o] && grantValid[o] && grantIdx[o] == 3'(c)) popEn[c] = 1'b1;
      end
      count_d[c] = count_q[c] + CNT_W'(wrEn[c]) - CNT_W'(popEn[c]);
    end
  end

  assign err_drop = |(headValid & headBad);

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    ptr_d      = ptr_q;
    for (int o = 0; o < 5; o++) begin
      if (outFree[o]) begin
        outValid_d[o] = grantValid[o];
        if (grantValid[o]) begin
          outData_d[o] = head[grantIdx[o]];
          ptr_d[o]     = wrapAdd(grantIdx[o], 3'd1);
        end
      end
    end
  end

  always_comb begin
    out_valid = outValid_q;
    for (int o = 0; o < 5; o++) out_data[o*PW +: PW] = outData_q[o];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 5; c++) begin
        wrPtr_q[c] <= '0;
        rdPtr_q[c] <= '0;
        count_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 5; c++) begin
        if (wrEn[c])  wrPtr_q[c] <= wrPtr_q[c] + PTR_W'(1);
        if (popEn[c]) rdPtr_q[c] <= rdPtr_q[c] + PTR_W'(1);
        count_q[c] <= count_d[c];
      end
    end
  end

  // Storage needs no reset: the occupancy counts alone decide what is visible.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 5; c++) begin
      if (wrEn[c]) mem_q[c][wrPtr_q[c]] <= in_data[c*PW +: PW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= '0;
      for (int o = 0; o < 5; o++) begin
        outData_q[o] <= '0;
        ptr_q[o]     <= '0;
      end
    end else begin
      outValid_q <= outValid_d;
      for (int o = 0; o < 5; o++) begin
        outData_q[o] <= outData_d[o];
        ptr_q[o]     <= ptr_d[o];
      end
    end
  end

`ifdef CIRC_ROUTER_STATS_EN
  logic [15:0] fwdCnt_q [5];
  logic [15:0] dropCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropCnt_q <= '0;
      for (int o = 0; o < 5; o++) fwdCnt_q[o] <= '0;
    end else begin
      if (err_drop) dropCnt_q <= dropCnt_q + 16'd1;
      for (int o = 0; o < 5; o++) begin
        if (outValid_q[o] & out_ready[o]) fwdCnt_q[o] <= fwdCnt_q[o] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < 5; o++) fwd_cnt[o*16 +: 16] = fwdCnt_q[o];
  end
  assign drop_cnt = dropCnt_q;
`endif

endmodule

// File: tb/tb_circ_router_buf.sv
// tb_circ_router_buf: directed and random checks of circ_router_buf against a flow-ordered scoreboard.
// Payload layout in this bench: {source channel[2:0], sequence[4:0]} so every delivery names its flow.
module tb_circ_router_buf;

  localparam int NODES  = 5;
  localparam int S2     = 2;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int PW     = ADDR_W + DATA_W;

  typedef struct packed {
    logic [2:0]    src;
    logic [2:0]    outp;
    logic [PW-1:0] pkt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] router_name;
  logic [4:0]        in_valid;
  logic [5*PW-1:0]   in_data;
  logic [4:0]        in_ready;
  logic [4:0]        out_valid;
  logic [5*PW-1:0]   out_data;
  logic [4:0]        out_ready;
  logic              err_drop;
`ifdef CIRC_ROUTER_STATS_EN
  logic [5*16-1:0]   fwd_cnt;
  logic [15:0]       drop_cnt;
`endif

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  int            seqCnt[5];
  int            delivered[5];
  int            dropSeen, dropExp, curName, sent, total, dst;
  logic [4:0]    acc;
  logic [PW-1:0] pkt, tmp;
  logic [PW-1:0] bp[5];
  int            dstTab[5] = '{1, 2, 3, 4, 0};
  int            outTab[5] = '{1, 2, 4, 3, 0};
  int            rrExp[6]  = '{0, 1, 3, 0, 1, 3};
  int            rrSrc[3]  = '{0, 1, 3};
  int            names[2]  = '{1, 4};

  circ_router_buf #(
    .NODES(NODES), .S2(S2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .router_name(router_name),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .err_drop   (err_drop)
`ifdef CIRC_ROUTER_STATS_EN
    ,
    .fwd_cnt    (fwd_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output port chosen by the ring-distance rule, straight from modular arithmetic.
  function automatic int routeOf(input int d, input int name);
    int r, l;
    r = (d - name + NODES) % NODES;
    l = NODES - r;
    if (r == 0) return 0;
    if (r <= l) return (r >= S2) ? 2 : 1;
    return (l >= S2) ? 4 : 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clearModel();
    sb.delete();
    dropSeen = 0;
    dropExp  = 0;
    acc      = '0;
    for (int i = 0; i < 5; i++) delivered[i] = 0;
  endtask

  task automatic applyReset(input int name);
    rst         = 1'b1;
    in_valid    = '0;
    in_data     = '0;
    out_ready   = 5'h1f;
    router_name = ADDR_W'(name);
    curName     = name;
    clearModel();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int c, input int d, output logic [PW-1:0] p);
    p = '0;
    p[PW-1 -: ADDR_W]  = ADDR_W'(d);
    p[DATA_W-1 -: 3]   = 3'(c);
    p[4:0]             = 5'(seqCnt[c]);
    seqCnt[c]++;
    in_valid[c]        = 1'b1;
    in_data[c*PW +: PW] = p;
  endtask

  // Samples handshakes on the falling edge, then advances to just after the next rising edge.
  task automatic stepClock();
    logic [PW-1:0] p;
    logic [2:0]    s;
    logic          found;
    int            idx;
    exp_t          e;
    @(negedge clk);
    acc = in_valid & in_ready;
    for (int c = 0; c < 5; c++) begin
      if (acc[c]) begin
        p = in_data[c*PW +: PW];
        if (int'(p[PW-1 -: ADDR_W]) >= NODES) dropExp++;
        else begin
          e.src  = 3'(c);
          e.outp = 3'(routeOf(int'(p[PW-1 -: ADDR_W]), curName));
          e.pkt  = p;
          sb.push_back(e);
        end
      end
    end
    for (int o = 0; o < 5; o++) begin
      if (out_valid[o] && out_ready[o]) begin
        p     = out_data[o*PW +: PW];
        s     = p[DATA_W-1 -: 3];
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < sb.size(); i++) begin
          if (!found && sb[i].src == s && sb[i].outp == 3'(o)) begin
            found = 1'b1;
            idx   = i;
          end
        end
        checkOutput("sb_match", 64'(found), 64'(1));
        if (found) begin
          checkOutput("sb_pkt", 64'(p), 64'(sb[idx].pkt));
          sb.delete(idx);
        end
        delivered[o]++;
      end
    end
    if (err_drop) dropSeen++;
    @(posedge clk);
    #1;
  endtask

  task automatic drainAll(input string tag);
    in_valid  = '0;
    out_ready = 5'h1f;
    for (int k = 0; k < 60 && sb.size() != 0; k++) stepClock();
    stepClock();
    checkOutput(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 5; i++) seqCnt[i] = 0;
    $display("[TB] reset and routing latency, router_name=0");
    applyReset(0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'(5'h1f));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    checkOutput("rst_err_drop", 64'(err_drop), 64'(0));

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, dstTab[i], pkt);
      checkOutput("lat_in_ready", 64'(in_ready[0]), 64'(1));
      stepClock();
      in_valid = '0;
      checkOutput("lat_early", 64'(out_valid), 64'(0));
      stepClock();
      checkOutput("lat_valid", 64'(out_valid), 64'(1) << outTab[i]);
      checkOutput("lat_data", 64'(out_data[outTab[i]*PW +: PW]), 64'(pkt));
      stepClock();
      checkOutput("lat_clear", 64'(out_valid), 64'(0));
    end

    $display("[TB] router_name=3, R1 input to dst=0");
    applyReset(3);
    applyStimulus(1, 0, pkt);
    stepClock();
    in_valid = '0;
    stepClock();
    checkOutput("r3_valid", 64'(out_valid), 64'(5'b00100));
    checkOutput("r3_data", 64'(out_data[2*PW +: PW]), 64'(pkt));
    stepClock();

    $display("[TB] invalid destination drop");
    applyReset(0);
    applyStimulus(0, 6, pkt);
    stepClock();
    in_valid = '0;
    checkOutput("drop_pulse", 64'(err_drop), 64'(1));
    checkOutput("drop_no_out", 64'(out_valid), 64'(0));
    stepClock();
    checkOutput("drop_end", 64'(err_drop), 64'(0));
    checkOutput("drop_drained", 64'(in_ready), 64'(5'h1f));
    stepClock();
    checkOutput("drop_still_idle", 64'(out_valid), 64'(0));
    checkOutput("drop_count", 64'(dropSeen), 64'(dropExp));
`ifdef CIRC_ROUTER_STATS_EN
    checkOutput("stat_drop_cnt", 64'(drop_cnt), 64'(1));
`endif

    $display("[TB] round-robin on output 1 from inputs 0, 1, 3");
    applyReset(0);
    for (int j = 0; j < 3; j++) applyStimulus(rrSrc[j], 1, tmp);
    stepClock();
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 3; j++) if (acc[rrSrc[j]]) applyStimulus(rrSrc[j], 1, tmp);
      stepClock();
      checkOutput("rr_valid", 64'(out_valid[1]), 64'(1));
      checkOutput("rr_src", 64'(out_data[PW+DATA_W-1 -: 3]), 64'(rrExp[i]));
    end
    drainAll("rr_drain");

    $display("[TB] backpressure on output 1");
    applyReset(0);
    out_ready = 5'b11101;
    sent = 0;
    applyStimulus(0, 1, bp[0]);
    for (int k = 0; k < 20 && sent < 5; k++) begin
      stepClock();
      if (acc[0]) begin
        sent++;
        if (sent < 5) applyStimulus(0, 1, bp[sent]);
        else in_valid[0] = 1'b0;
      end
    end
    checkOutput("bp_sent", 64'(sent), 64'(5));
    checkOutput("bp_held_valid", 64'(out_valid[1]), 64'(1));
    checkOutput("bp_held_data", 64'(out_data[PW +: PW]), 64'(bp[0]));
    checkOutput("bp_full", 64'(in_ready[0]), 64'(0));
    stepClock();
    stepClock();
    checkOutput("bp_stable", 64'(out_data[PW +: PW]), 64'(bp[0]));
    checkOutput("bp_still_full", 64'(in_ready[0]), 64'(0));
    out_ready = 5'h1f;
    for (int k = 0; k < 20 && delivered[1] < 5; k++) stepClock();
    checkOutput("bp_delivered", 64'(delivered[1]), 64'(5));
    checkOutput("bp_sb_empty", 64'(sb.size()), 64'(0));
    checkOutput("bp_ready_back", 64'(in_ready), 64'(5'h1f));

    $display("[TB] asynchronous reset with packets buffered");
    applyReset(0);
    out_ready = 5'b11101;
    sent = 0;
    applyStimulus(0, 1, tmp);
    for (int k = 0; k < 20 && sent < 3; k++) begin
      stepClock();
      if (acc[0]) begin
        sent++;
        if (sent < 3) applyStimulus(0, 1, tmp);
        else in_valid[0] = 1'b0;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("arst_in_ready", 64'(in_ready), 64'(5'h1f));
    checkOutput("arst_out_data", 64'(out_data), 64'(0));
    clearModel();
    rst       = 1'b0;
    out_ready = 5'h1f;
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) stepClock();
    total = 0;
    for (int o = 0; o < 5; o++) total += delivered[o];
    checkOutput("arst_no_stale", 64'(total), 64'(0));
    checkOutput("arst_idle", 64'(out_valid), 64'(0));

    $display("[TB] random traffic");
    for (int n = 0; n < 2; n++) begin
      applyReset(names[n]);
      for (int k = 0; k < 300; k++) begin
        for (int c = 0; c < 5; c++) begin
          if (!in_valid[c] || acc[c]) begin
            if ($urandom_range(0, 2) != 0) begin
              if (c == 0 && $urandom_range(0, 7) == 0) dst = int'($urandom_range(NODES, 7));
              else dst = int'($urandom_range(0, NODES-1));
              applyStimulus(c, dst, tmp);
            end else begin
              in_valid[c] = 1'b0;
            end
          end
        end
        out_ready = 5'($urandom);
        stepClock();
      end
      drainAll("rand_drain");
      checkOutput("rand_drops", 64'(dropSeen), 64'(dropExp));
      checkOutput("rand_ready", 64'(in_ready), 64'(5'h1f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
